pipe_strm_driver: RTL and testbench
===================================

Name: pipe_strm_driver

Overview:
- Parent-side controller for a TyBEC pipelined compute kernel, sitting on the other end of the kernel's start/stop/ready/done/cts interface.
- Reads NumElem words from a source buffer and streams them into the kernel, driving start on the first element and stop on the last.
- Captures kernel output words into a destination buffer while cts is high, and closes the transaction on done.
- Instantiated once per kernel inside the generated top level, between on-chip buffers and the compute pipe.

Parameters:
- DataW, 32, stream word width.
- NumElem, 1024, elements per run; must be ≥1.
- AddrW, 10, buffer address width; 2**AddrW ≥ NumElem.

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, reset, asynchronous, active-low.
- go, in, 1, run request, sampled only in IDLE.
- busy, out, 1, high from the cycle after go is accepted until finished.
- finished, out, 1, one-cycle pulse at end of run.
- err, out, 1, sticky element-count mismatch flag; cleared on next accepted go.
- src_re, out, 1, source buffer read enable.
- src_addr, out, AddrW, source read address.
- src_rdata, in, DataW, source data, valid one cycle after src_re.
- strm_out, out, DataW, data to kernel input stream; equals src_rdata.
- start, out, 1, high with the first element presented to the kernel.
- stop, out, 1, high with the last element presented to the kernel.
- pipe_ready, in, 1, kernel ready; observed only, no functional effect.
- pipe_cts, in, 1, kernel clear-to-send; output data valid while high.
- pipe_done, in, 1, kernel last output valid this cycle.
- strm_in, in, DataW, kernel output stream.
- dst_we, out, 1, destination write enable.
- dst_addr, out, AddrW, destination write address.
- dst_wdata, out, DataW, equals strm_in.
- wr_count, out, AddrW+1, elements written this run.

Behaviour:
- Reset (rst=0, async) values: all outputs 0, state IDLE, counters 0.
- State machine:
  - IDLE: go=1 → FEED; clears err, wr_count, and both address counters.
  - FEED: src_re=1 every cycle, src_addr = 0..NumElem-1 incrementing by 1; after issuing NumElem-1 → DRAIN.
  - DRAIN: wait for the done condition (below) → FIN.
  - FIN: finished=1 for exactly one cycle → IDLE.
- Read valid: rd_vld is a one-cycle-delayed copy of src_re. A flag marks the first read of the run.
- start = rd_vld AND first-element flag. stop = rd_vld AND last-element flag. Both are registered so they align with src_rdata.
- NumElem=1: start and stop are high in the same cycle.
- Write window:
  - wr_act sets on the cycle start is driven; clears after the cycle pipe_done is sampled high.
  - dst_we = pipe_cts AND wr_act. dst_addr increments after each write and starts at 0.
  - cts stays high between runs; wr_act is the only gate. No writes occur outside a run.
- Done condition: pipe_done=1 while wr_act=1. The write in that same cycle is performed.
- pipe_done arriving during FEED (illegal kernel behaviour) is latched. DRAIN then exits on the next cycle; err is set if the feature is enabled.
- dst_addr wraps modulo 2**AddrW. wr_count saturates at all-ones.
- go is ignored outside IDLE. go high in the FIN cycle is ignored; it is accepted the following cycle if still high.
- Reset mid-run: immediate return to IDLE with all outputs at 0. No finished pulse.
- Latency: go sampled at cycle 0 → src_re from cycle 1, start at cycle 2, stop at cycle NumElem+1. finished comes 1 cycle after pipe_done.

Optional Feature:
- PIPE_DRV_CNTCHK_EN defined: on the done condition, if wr_count (including the done-cycle write) ≠ NumElem, err sets. err also sets on early pipe_done. err is sticky until next go.
- Undefined: err tied to 0; the count compare logic is absent.

Test Plan:
- NumElem=4, 3-stage kernel model (ready=start delayed 2, cts registered from ready, done=stop delayed 3), src mem[i]=i+1.
  - go at cycle 0 → src_addr 0..3 at cycles 1-4; start at cycle 2; stop at cycle 5.
  - dst_we at cycles 5-8 with dst_addr 0..3.
  - finished at cycle 9; wr_count=4; err=0.
- NumElem=1 → start and stop both high at cycle 2; single write at dst_addr 0; finished pulses once.
- Second run with cts held high from the previous run → no dst_we before the new start; dst_addr restarts at 0.
- Kernel model drops one cts cycle with feature enabled → wr_count=3, err=1 after finished. Same stimulus with feature disabled → err=0.
- Reset asserted in FEED at cycle 3 → all outputs 0 asynchronously. After release, a new go gives src_addr=0 at cycle 1.
- go held high continuously over two runs → second run's src_re begins 2 cycles after the first run's finished pulse.

Source files
------------

// File: rtl/pipe_strm_driver.sv
// Parent-side stream driver for a pipelined compute kernel: feeds NumElem source words, captures results.
// Optional element-count check is compiled in when PIPE_DRV_CNTCHK_EN is defined.
module pipe_strm_driver #(
   parameter int DataW   = 32,
   parameter int NumElem = 1024,
   parameter int AddrW   = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   output logic             busy,
   output logic             finished,
   output logic             err,
   output logic             src_re,
   output logic [AddrW-1:0] src_addr,
   input  logic [DataW-1:0] src_rdata,
   output logic [DataW-1:0] strm_out,
   output logic             start,
   output logic             stop,
   input  logic             pipe_ready,
   input  logic             pipe_cts,
   input  logic             pipe_done,
   input  logic [DataW-1:0] strm_in,
   output logic             dst_we,
   output logic [AddrW-1:0] dst_addr,
   output logic [DataW-1:0] dst_wdata,
   output logic [AddrW:0]   wr_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

   localparam logic [AddrW-1:0] LAST_ADDR = AddrW'(NumElem - 1);

   state_t state, state_next;
   logic   go_acc;
   logic   first_flag;
   logic   wr_act;
   logic   done_seen;
   logic   done_cond;
   logic   early_done;
   logic   unused_ready;

   assign go_acc       = (state == IDLE) && go;
   assign done_cond    = pipe_done && wr_act;
   assign early_done   = (state == FEED) && pipe_done;
   assign dst_we       = pipe_cts && wr_act;
   assign strm_out     = src_rdata;
   assign dst_wdata    = strm_in;
   assign unused_ready = pipe_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (go) state_next = FEED;
         FEED:  if (src_addr == LAST_ADDR) state_next = DRAIN;
         // a done latched during FEED lets DRAIN exit straight away
         DRAIN: if (done_seen || done_cond) state_next = FIN;
         FIN:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      src_re   = (state == FEED);
      busy     = (state != IDLE);
      finished = (state == FIN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_addr   <= '0;
         dst_addr   <= '0;
         wr_count   <= '0;
         first_flag <= 1'b0;
         wr_act     <= 1'b0;
         done_seen  <= 1'b0;
         start      <= 1'b0;
         stop       <= 1'b0;
      end else begin
         // start/stop are registered so they line up with src_rdata
         start <= src_re && first_flag;
         stop  <= src_re && (src_addr == LAST_ADDR);
         if (go_acc) begin
            src_addr   <= '0;
            dst_addr   <= '0;
            wr_count   <= '0;
            first_flag <= 1'b1;
            wr_act     <= 1'b0;
            done_seen  <= 1'b0;
         end else begin
            if (src_re) begin
               src_addr   <= src_addr + 1'b1;
               first_flag <= 1'b0;
            end
            if (dst_we) begin
               dst_addr <= dst_addr + 1'b1;
               if (wr_count != {(AddrW+1){1'b1}}) wr_count <= wr_count + 1'b1;
            end
            if (done_cond)  wr_act <= 1'b0;
            else if (start) wr_act <= 1'b1;
            if (early_done) done_seen <= 1'b1;
         end
      end
   end

`ifdef PIPE_DRV_CNTCHK_EN
   localparam logic [AddrW+1:0] NUM_ELEM_W = (AddrW+2)'(NumElem);

   logic             err_reg;
   logic [AddrW+1:0] cnt_final;

   // count as it will stand once the done-cycle write lands
   assign cnt_final = {1'b0, wr_count} + {{(AddrW+1){1'b0}}, dst_we};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                        err_reg <= 1'b0;
      else if (go_acc)                                 err_reg <= 1'b0;
      else if (early_done)                             err_reg <= 1'b1;
      else if (done_cond && (cnt_final != NUM_ELEM_W)) err_reg <= 1'b1;
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_strm_driver.sv
// Self-checking bench for pipe_strm_driver: two instances (NumElem=4 and NumElem=1) with a 3-stage kernel model.
// Expected err depends on whether PIPE_DRV_CNTCHK_EN is defined for the build.
module tb_pipe_strm_driver;

   localparam int AW = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          go        [2];
   logic          busy      [2];
   logic          finished  [2];
   logic          err       [2];
   logic          src_re    [2];
   logic [AW-1:0] src_addr  [2];
   logic [DW-1:0] strm_out  [2];
   logic          start     [2];
   logic          stop      [2];
   logic          pipe_ready[2];
   logic          pipe_cts  [2];
   logic          pipe_done [2];
   logic [DW-1:0] strm_in   [2];
   logic          dst_we    [2];
   logic [AW-1:0] dst_addr  [2];
   logic [DW-1:0] dst_wdata [2];
   logic [AW:0]   wr_count  [2];

   logic [DW-1:0] mem [2][16];
   logic [DW-1:0] key [2];
   logic          force_hi [2] = '{1'b0, 1'b0};
   int            drop_at  [2] = '{-1, -1};

   int errs   = 0;
   int checks = 0;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         logic          inside_q, r1, r2, c_q, d1, d2, d3;
         logic [DW-1:0] s1, s2, s3, rdata_q;
         logic          in_v;

         pipe_strm_driver #(.DataW(DW), .NumElem(gi == 0 ? 4 : 1), .AddrW(AW)) u_dut (
            .clk(clk), .rst(rst), .go(go[gi]), .busy(busy[gi]), .finished(finished[gi]),
            .err(err[gi]), .src_re(src_re[gi]), .src_addr(src_addr[gi]), .src_rdata(rdata_q),
            .strm_out(strm_out[gi]), .start(start[gi]), .stop(stop[gi]),
            .pipe_ready(pipe_ready[gi]), .pipe_cts(pipe_cts[gi]), .pipe_done(pipe_done[gi]),
            .strm_in(strm_in[gi]), .dst_we(dst_we[gi]), .dst_addr(dst_addr[gi]),
            .dst_wdata(dst_wdata[gi]), .wr_count(wr_count[gi])
         );

         always @(posedge clk) if (src_re[gi]) rdata_q <= mem[gi][src_addr[gi]];

         // kernel: ready = input window delayed 2, cts = ready registered, done = stop delayed 3
         assign in_v = start[gi] | inside_q;
         always @(posedge clk or negedge rst) begin
            if (!rst) begin
               inside_q <= 1'b0; r1 <= 1'b0; r2 <= 1'b0; c_q <= 1'b0;
               d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0; s1 <= '0; s2 <= '0; s3 <= '0;
            end else begin
               inside_q <= start[gi] ? !stop[gi] : (stop[gi] ? 1'b0 : inside_q);
               r1 <= in_v; r2 <= r1; c_q <= r2;
               d1 <= stop[gi]; d2 <= d1; d3 <= d2;
               s1 <= strm_out[gi] ^ key[gi]; s2 <= s1; s3 <= s2;
            end
         end
         assign pipe_ready[gi] = r2;
         assign pipe_cts[gi]   = (c_q && (cyc != drop_at[gi])) || force_hi[gi];
         assign pipe_done[gi]  = d3;
         assign strm_in[gi]    = s3;
      end
   endgenerate

   task automatic test_reset();
      go[0] = 1'b0; go[1] = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({busy[d], finished[d], err[d], src_re[d], start[d], stop[d], dst_we[d]} !== 7'b0) begin
            errs++;
            $display("FAIL reset_ctrl dut%0d got=%b exp=0000000", d,
                     {busy[d], finished[d], err[d], src_re[d], start[d], stop[d], dst_we[d]});
         end
         checks++;
         if ({src_addr[d], dst_addr[d], wr_count[d]} !== 13'b0) begin
            errs++;
            $display("FAIL reset_cnt dut%0d src_addr=%0d dst_addr=%0d wr_count=%0d exp=0",
                     d, src_addr[d], dst_addr[d], wr_count[d]);
         end
      end
      #2 rst = 1'b1;
      $display("reset: both instances idle");
   endtask

   // One run from go; reference derives every expectation from cycle index and the kernel inputs.
   task automatic run_check(input int d, input string name, input bit normal, input int drop_rel);
      int n, base, done_c, writes;
      logic exp_re, exp_we, exp_fin, exp_err, in_win;
      logic [DW-1:0] exp_data;
      n = (d == 0) ? 4 : 1;
      for (int k = 0; k < 16; k++) mem[d][k] = $urandom;
      key[d] = $urandom;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 go[d] = 1'b1;
      base = cyc;
      if (drop_rel >= 0) drop_at[d] = base + drop_rel;
      done_c = -1;
      writes = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         exp_re = (c >= 1) && (c <= n);
         checks++;
         if (src_re[d] !== exp_re) begin
            errs++; $display("FAIL %s src_re c%0d got=%b exp=%b", name, c, src_re[d], exp_re);
         end
         if (exp_re) begin
            checks++;
            if (src_addr[d] !== AW'(c - 1)) begin
               errs++; $display("FAIL %s src_addr c%0d got=%0d exp=%0d", name, c, src_addr[d], c - 1);
            end
         end
         checks++;
         if ({start[d], stop[d]} !== {(c == 2), (c == n + 1)}) begin
            errs++; $display("FAIL %s start_stop c%0d got=%b%b exp=%b%b", name, c, start[d], stop[d],
                             (c == 2), (c == n + 1));
         end
         if (c >= 2 && c <= n + 1) begin
            checks++;
            if (strm_out[d] !== mem[d][c - 2]) begin
               errs++; $display("FAIL %s strm_out c%0d got=%h exp=%h", name, c, strm_out[d], mem[d][c - 2]);
            end
         end
         checks++;
         if (busy[d] !== (c >= 1)) begin
            errs++; $display("FAIL %s busy c%0d got=%b exp=%b", name, c, busy[d], (c >= 1));
         end
         in_win = (c > 2) && (done_c < 0);
         exp_we = in_win && pipe_cts[d];
         checks++;
         if (dst_we[d] !== exp_we) begin
            errs++; $display("FAIL %s dst_we c%0d got=%b exp=%b", name, c, dst_we[d], exp_we);
         end
         if (exp_we) begin
            exp_data = normal ? (mem[d][writes] ^ key[d]) : strm_in[d];
            checks++;
            if (dst_addr[d] !== AW'(writes) || dst_wdata[d] !== exp_data) begin
               errs++; $display("FAIL %s write c%0d addr got=%0d exp=%0d data got=%h exp=%h", name, c,
                                dst_addr[d], AW'(writes), dst_wdata[d], exp_data);
            end
            writes++;
         end
         exp_fin = (done_c >= 0) && (c == done_c + 1);
         checks++;
         if (finished[d] !== exp_fin) begin
            errs++; $display("FAIL %s finished c%0d got=%b exp=%b", name, c, finished[d], exp_fin);
         end
         if (in_win && pipe_done[d]) done_c = c;
         if (c == 0) begin
            @(posedge clk);
            #1 go[d] = 1'b0;
         end
         if (exp_fin) break;
      end
      drop_at[d] = -1;
      checks++;
      if (done_c < 0) begin
         errs++; $display("FAIL %s timeout waiting for pipe_done got=none exp=done", name);
      end
`ifdef PIPE_DRV_CNTCHK_EN
      exp_err = (writes != n);
`else
      exp_err = 1'b0;
`endif
      @(negedge clk);
      checks++;
      if (wr_count[d] !== (AW+1)'(writes) || err[d] !== exp_err || busy[d] !== 1'b0 || finished[d] !== 1'b0) begin
         errs++; $display("FAIL %s end wr_count got=%0d exp=%0d err got=%b exp=%b busy=%b finished=%b",
                          name, wr_count[d], writes, err[d], exp_err, busy[d], finished[d]);
      end
      $display("run %s dut%0d: writes=%0d wr_count=%0d err=%b", name, d, writes, wr_count[d], err[d]);
   endtask

   task automatic test_basic();
      run_check(0, "n4", 1'b1, -1);
      run_check(1, "n1", 1'b1, -1);
   endtask

   task automatic test_back_to_back();
      force_hi[0] = 1'b1;
      run_check(0, "cts_held", 1'b0, -1);
      force_hi[0] = 1'b0;
   endtask

   task automatic test_cts_drop();
      run_check(0, "cts_drop", 1'b0, 6);
   endtask

   task automatic test_reset_mid_run();
      @(posedge clk);
      #1 go[0] = 1'b1;
      @(posedge clk);
      #1 go[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (src_re[0] !== 1'b1 || src_addr[0] !== 4'd2) begin
         errs++; $display("FAIL midrst_feed got re=%b addr=%0d exp re=1 addr=2", src_re[0], src_addr[0]);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({busy[0], finished[0], err[0], src_re[0], start[0], stop[0], dst_we[0]} !== 7'b0 ||
          {src_addr[0], dst_addr[0], wr_count[0]} !== 13'b0) begin
         errs++; $display("FAIL midrst_async got ctrl=%b addr=%0d cnt=%0d exp all 0",
                          {busy[0], finished[0], err[0], src_re[0], start[0], stop[0], dst_we[0]},
                          src_addr[0], wr_count[0]);
      end
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (finished[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errs++; $display("FAIL midrst_idle c%0d got fin=%b busy=%b exp 0 0", c, finished[0], busy[0]);
         end
      end
      $display("reset mid-run: instance returned to idle");
      run_check(0, "after_rst", 1'b1, -1);
   endtask

   task automatic test_go_held();
      int f1, s2;
      bit fin2;
      f1 = -1; s2 = -1; fin2 = 1'b0;
      @(posedge clk);
      #1 go[0] = 1'b1;
      for (int c = 0; c < 60 && s2 < 0; c++) begin
         @(negedge clk);
         if (finished[0] && f1 < 0) f1 = c;
         else if (f1 >= 0 && src_re[0]) begin
            s2 = c;
            checks++;
            if (src_addr[0] !== 4'd0) begin
               errs++; $display("FAIL goheld_addr got=%0d exp=0", src_addr[0]);
            end
         end
      end
      go[0] = 1'b0;
      checks++;
      if (s2 < 0 || f1 < 0) begin
         errs++; $display("FAIL goheld_timeout got fin=%0d re=%0d exp both seen", f1, s2);
      end else if (s2 - f1 != 2) begin
         errs++; $display("FAIL goheld_gap got=%0d exp=2", s2 - f1);
      end
      for (int c = 0; c < 40 && !fin2; c++) begin
         @(negedge clk);
         if (finished[0]) fin2 = 1'b1;
      end
      checks++;
      if (!fin2) begin
         errs++; $display("FAIL goheld_second_fin got=none exp=pulse");
      end
      $display("go held: finished at %0d, restart at %0d", f1, s2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_cts_drop();
      test_reset_mid_run();
      test_go_held();
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
